// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the LO/HI multiply/divide unit.
//   - op encodings driven on op_i by the execute stage
//   - FSM state encoding
//   - MULDIV_LATENCY: cycles from start to LO/HI write on the iterative path
package muldiv_pkg;

    localparam int unsigned DATA_BITS_DEFAULT = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2
    } muldiv_state_e;

    // One radix-2 step per operand bit, plus the sign-fix/writeback cycle.
    function automatic int unsigned muldiv_latency(input int unsigned bits);
        return bits + 1;
    endfunction

    localparam int unsigned MULDIV_LATENCY = muldiv_latency(DATA_BITS_DEFAULT);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_i          partial remainder before the step
//   dividend_bit_i next dividend bit shifted into the remainder
//   divisor_i      divisor (unsigned magnitude)
//   rem_o          partial remainder after the step
//   q_bit_o        quotient bit produced by the step
module div_step
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic [DATA_BITS-1:0] rem_i,
    input  logic                 dividend_bit_i,
    input  logic [DATA_BITS-1:0] divisor_i,
    output logic [DATA_BITS-1:0] rem_o,
    output logic                 q_bit_o
);

    logic [DATA_BITS:0]   shifted;
    logic [DATA_BITS-1:0] diff;

    always_comb begin
        shifted = {rem_i, dividend_bit_i};
        q_bit_o = (shifted >= {1'b0, divisor_i});
        // When the subtract is taken the result is below the divisor, so the
        // low word of the difference is exact.
        diff    = shifted[DATA_BITS-1:0] - divisor_i;
        rem_o   = q_bit_o ? diff : shifted[DATA_BITS-1:0];
    end

endmodule

// File: rtl/lohi_muldiv_unit.sv
// lohi_muldiv_unit: iterative multiply/divide unit owning the LO/HI registers.
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i, op_i   launch MULT/MULTU/DIV/DIVU (ignored while busy_o)
//   a_i, b_i        rs / rt operands; a_i is also the MTLO/MTHI data
//   mtlo_i, mthi_i  move a_i into LO / HI when idle (dropped if start_i)
//   busy_o          operation in flight, LO/HI stale
//   done_o          one-cycle pulse after LO/HI take a result
//   lo_o, hi_o      LO / HI registers
// Optional feature: define LOHI_FAST_MULT_EN for single-cycle MULT/MULTU.
module lohi_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [DATA_BITS-1:0] a_i,
    input  logic [DATA_BITS-1:0] b_i,
    input  logic                 mtlo_i,
    input  logic                 mthi_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATA_BITS-1:0] lo_o,
    output logic [DATA_BITS-1:0] hi_o
);

    localparam int unsigned    W2      = 2 * DATA_BITS;
    localparam int unsigned    CntW    = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_BITS - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    muldiv_state_e state_q, state_d;

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [W2-1:0]        acc_q, acc_d;    // mult: {partial, multiplier}; div: {rem, dividend/quo}
    logic [DATA_BITS-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [DATA_BITS-1:0] lo_q, lo_d;
    logic [DATA_BITS-1:0] hi_q, hi_d;
    logic                 done_q, done_d;

    logic                 signed_op, neg_a, neg_b;
    logic [DATA_BITS-1:0] abs_a, abs_b;
    logic [DATA_BITS-1:0] mul_addend;
    logic [DATA_BITS:0]   mul_sum;
    logic [DATA_BITS-1:0] div_rem;
    logic                 div_qbit;
    logic [W2-1:0]        prod_fix;
    logic [DATA_BITS-1:0] quo_raw, rem_raw, quo_fix, rem_fix;
    logic [W2-1:0]        fast_prod;
    logic                 fast_hit;

`ifdef LOHI_FAST_MULT_EN
    logic [W2-1:0] fast_a, fast_b;
    // Sign-extend for MULT; the low 2N bits of the product are then exact.
    assign fast_a    = (op_i == OP_MULT) ? {{DATA_BITS{a_i[DATA_BITS-1]}}, a_i}
                                         : {{DATA_BITS{1'b0}}, a_i};
    assign fast_b    = (op_i == OP_MULT) ? {{DATA_BITS{b_i[DATA_BITS-1]}}, b_i}
                                         : {{DATA_BITS{1'b0}}, b_i};
    assign fast_prod = fast_a * fast_b;
    assign fast_hit  = start_i && !op_i[1];
`else
    assign fast_prod = '0;
    assign fast_hit  = 1'b0;
`endif

    // Operand magnitudes for the unsigned iterative datapath.
    assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign neg_a     = signed_op & a_i[DATA_BITS-1];
    assign neg_b     = signed_op & b_i[DATA_BITS-1];
    assign abs_a     = neg_a ? -a_i : a_i;
    assign abs_b     = neg_b ? -b_i : b_i;

    // Shift-add multiply step.
    assign mul_addend = acc_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_q[W2-1:DATA_BITS]} + {1'b0, mul_addend};

    div_step #(
        .DATA_BITS(DATA_BITS)
    ) u_div_step (
        .rem_i         (acc_q[W2-1:DATA_BITS]),
        .dividend_bit_i(acc_q[DATA_BITS-1]),
        .divisor_i     (opnd_q),
        .rem_o         (div_rem),
        .q_bit_o       (div_qbit)
    );

    // Sign correction. Divide-by-zero leaves |a| in the remainder, so the
    // dividend-sign fix restores the raw a for HI.
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_raw  = acc_q[DATA_BITS-1:0];
    assign rem_raw  = acc_q[W2-1:DATA_BITS];
    assign quo_fix  = (opnd_q == '0) ? '1 : ((sign_a_q ^ sign_b_q) ? -quo_raw : quo_raw);
    assign rem_fix  = sign_a_q ? -rem_raw : rem_raw;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i && !fast_hit) state_d = StCalc;
            StCalc:  if (cnt_q == CntLast) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o = (state_q != StIdle);
    end

    assign done_o = done_q;
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

    // Datapath next-state.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fast_hit) begin
                    lo_d   = fast_prod[DATA_BITS-1:0];
                    hi_d   = fast_prod[W2-1:DATA_BITS];
                    done_d = 1'b1;
                end else if (start_i) begin
                    cnt_d    = '0;
                    is_div_d = op_i[1];
                    sign_a_d = neg_a;
                    sign_b_d = neg_b;
                    if (op_i[1]) begin
                        acc_d  = {{DATA_BITS{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{DATA_BITS{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                end else begin
                    if (mtlo_i) lo_d = a_i;
                    if (mthi_i) hi_d = a_i;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CntOne;
                if (is_div_q) begin
                    acc_d = {div_rem, acc_q[DATA_BITS-2:0], div_qbit};
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_BITS-1:1]};
                end
            end
            StFix: begin
                cnt_d  = '0;
                done_d = 1'b1;
                lo_d   = is_div_q ? quo_fix : prod_fix[DATA_BITS-1:0];
                hi_d   = is_div_q ? rem_fix : prod_fix[W2-1:DATA_BITS];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_lohi_muldiv_unit.sv
// tb_lohi_muldiv_unit: directed plus randomized checks of lohi_muldiv_unit
// against a 64-bit arithmetic reference model. Honours LOHI_FAST_MULT_EN.
module tb_lohi_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        mtlo_i = 1'b0;
    logic        mthi_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] lo_o, hi_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_lo = '0;
    logic [31:0] exp_hi = '0;
    logic [31:0] pend_lo, pend_hi;
    logic [1:0]  pend_op;
    int          edges;
`ifdef LOHI_FAST_MULT_EN
    bit          fast_mult = 1'b1;
`else
    bit          fast_mult = 1'b0;
`endif

    lohi_muldiv_unit #(
        .DATA_BITS(32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start_i),
        .op_i   (op_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .mtlo_i (mtlo_i),
        .mthi_i (mthi_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .lo_o   (lo_o),
        .hi_o   (hi_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // MIPS LO/HI semantics computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            2'd0: begin sp = sa * sb; return sp; end
            2'd1: begin up = ua * ub; return up; end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mlo, input logic mhi);
        logic [63:0] r;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; mtlo_i = mlo; mthi_i = mhi;
        @(posedge clk);
        #1;
        start_i = 1'b0; mtlo_i = 1'b0; mthi_i = 1'b0;
        r       = ref_model(op, a, b);
        pend_lo = r[31:0];
        pend_hi = r[63:32];
        pend_op = op;
        edges   = 0;
    endtask

    task automatic finish_op(input string tag);
        bit ok_busy, ok_hold;
        int lat;
        ok_busy = 1'b1;
        ok_hold = 1'b1;
        lat     = (fast_mult && !pend_op[1]) ? 0 : 33;
        while (done_o !== 1'b1 && edges < 40) begin
            if (busy_o !== 1'b1) ok_busy = 1'b0;
            if (lo_o !== exp_lo || hi_o !== exp_hi) ok_hold = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, " latency"}, edges, lat);
        check({tag, " busy held"}, {31'd0, ok_busy}, 32'd1);
        check({tag, " lohi held"}, {31'd0, ok_hold}, 32'd1);
        check({tag, " busy low at done"}, {31'd0, busy_o}, 32'd0);
        check({tag, " lo"}, lo_o, pend_lo);
        check({tag, " hi"}, hi_o, pend_hi);
        exp_lo = pend_lo;
        exp_hi = pend_hi;
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, {31'd0, done_o}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        launch(op, a, b, 1'b0, 1'b0);
        finish_op(tag);
    endtask

    task automatic move(input string tag, input logic mlo, input logic mhi, input logic [31:0] v);
        @(negedge clk);
        mtlo_i = mlo; mthi_i = mhi; a_i = v;
        @(posedge clk);
        #1;
        mtlo_i = 1'b0; mthi_i = 1'b0;
        if (mlo) exp_lo = v;
        if (mhi) exp_hi = v;
        check({tag, " lo"}, lo_o, exp_lo);
        check({tag, " hi"}, hi_o, exp_hi);
        check({tag, " no done"}, {31'd0, done_o}, 32'd0);
        check({tag, " no busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] edge_vals [6];
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

        #12;
        check("reset lo", lo_o, 32'd0);
        check("reset hi", hi_o, 32'd0);
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult neg", 2'd0, 32'hFFFF_FFFE, 32'd3);
        run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 2'd3, 32'd7, 32'd2);
        run_op("divu by zero", 2'd3, 32'h0000_1234, 32'd0);
        run_op("div overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div neg by zero", 2'd2, 32'hFFFF_FF00, 32'd0);

        move("mtlo", 1'b1, 1'b0, 32'h0000_00AA);
        move("mtlo mthi", 1'b1, 1'b1, 32'h0000_1357);

        // start wins over a simultaneous mthi; HI must keep its old value in CALC.
        launch(2'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        finish_op("start plus mthi");

        // Pulses while busy must be ignored.
        launch(2'd2, 32'd1000, 32'hFFFF_FFFD, 1'b0, 1'b0);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'd1; a_i = 32'h0000_DEAD; b_i = 32'd2; mtlo_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0; mtlo_i = 1'b0;
        edges = 1;
        finish_op("ignore while busy");

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        // Reset in the middle of a divide.
        move("preload", 1'b1, 1'b1, 32'h0000_0077);
        launch(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop reset lo", lo_o, 32'd0);
        check("midop reset hi", hi_o, 32'd0);
        check("midop reset busy", {31'd0, busy_o}, 32'd0);
        check("midop reset done", {31'd0, done_o}, 32'd0);
        exp_lo = '0;
        exp_hi = '0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op("after reset multu", 2'd1, 32'd3, 32'd4);
        run_op("after reset mult", 2'd0, 32'hFFFF_FFFE, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
